// File: rtl/ceu_cap_check_pkg.sv
// lynxTypes: shared widths, request/capability types and reject cause encodings for the CEU capability checker
package lynxTypes;

    localparam int VADDR_BITS = 48;
    localparam int LEN_BITS   = 28;
    localparam int PID_BITS   = 6;

    localparam logic [1:0] CAP_ERR_NONE   = 2'd0;
    localparam logic [1:0] CAP_ERR_NOCAP  = 2'd1;
    localparam logic [1:0] CAP_ERR_PERM   = 2'd2;
    localparam logic [1:0] CAP_ERR_BOUNDS = 2'd3;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [PID_BITS-1:0]   pid;
    } req_t;

    typedef struct packed {
        logic [VADDR_BITS-1:0] base;
        logic [LEN_BITS-1:0]   len;
        logic [1:0]            perm;
    } cap_t;

    // Prioritised check; ends are formed one bit wider so a carry out of the address space is seen, never wrapped.
    // An out-of-range pid reaches here as an entry with perm 0, so it lands in the no-capability cause.
    function automatic logic [1:0] cap_cause(input req_t r, input cap_t c, input logic is_wr);
        logic [VADDR_BITS:0] req_end;
        logic [VADDR_BITS:0] cap_end;
        req_end = {1'b0, r.vaddr} + (VADDR_BITS+1)'(r.len);
        cap_end = {1'b0, c.base} + (VADDR_BITS+1)'(c.len);
        if (c.perm == 2'b00)
            return CAP_ERR_NOCAP;
        if (!(is_wr ? c.perm[1] : c.perm[0]))
            return CAP_ERR_PERM;
        if (r.len == '0 || r.vaddr < c.base || req_end[VADDR_BITS] || req_end > cap_end)
            return CAP_ERR_BOUNDS;
        return CAP_ERR_NONE;
    endfunction

endpackage

// File: rtl/ceu_cap_check_table.sv
// ceu_cap_table: capability table with one synchronous write port and one registered read port
module ceu_cap_table
    import lynxTypes::*;
#(
    parameter int N_CAPS = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                wr_en,
    input  logic [PID_BITS-1:0] wr_idx,
    input  cap_t                wr_cap,
    input  logic                rd_en,
    input  logic [PID_BITS-1:0] rd_idx,
    output cap_t                rd_cap
);

    localparam int IW = N_CAPS > 1 ? $clog2(N_CAPS) : 1;

    logic [VADDR_BITS-1:0] base_q [N_CAPS];
    logic [LEN_BITS-1:0]   len_q  [N_CAPS];
    logic [1:0]            perm_q [N_CAPS];
    logic                  wr_hit;
    logic                  rd_hit;

    assign wr_hit = wr_en && ({1'b0, wr_idx} < (PID_BITS+1)'(N_CAPS));
    assign rd_hit = {1'b0, rd_idx} < (PID_BITS+1)'(N_CAPS);

    // Address window storage; validity lives in perm, so these need no reset
    always_ff @(posedge aclk) begin
        if (wr_hit) begin
            base_q[wr_idx[IW-1:0]] <= wr_cap.base;
            len_q[wr_idx[IW-1:0]]  <= wr_cap.len;
        end
    end

    // Permissions clear on reset so every entry starts invalid
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CAPS; i++)
                perm_q[i] <= 2'b00;
        end else if (wr_hit) begin
            perm_q[wr_idx[IW-1:0]] <= wr_cap.perm;
        end
    end

    // Registered read samples the pre-write contents; out-of-range pids read as an empty entry
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rd_cap <= '0;
        else if (rd_en)
            rd_cap <= rd_hit ? '{base: base_q[rd_idx[IW-1:0]], len: len_q[rd_idx[IW-1:0]], perm: perm_q[rd_idx[IW-1:0]]} : '0;
    end

endmodule

// File: rtl/ceu_cap_check.sv
// ceu_cap_check: two-stage capability check that forwards permitted user requests and drops/reports the rest
module ceu_cap_check
    import lynxTypes::*;
#(
    parameter int N_CAPS = 16,
    parameter bit IS_WR  = 1'b0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  req_t                  s_req_data,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output req_t                  m_req_data,
    input  logic                  cap_wr_en,
    input  logic [PID_BITS-1:0]   cap_idx,
    input  logic [VADDR_BITS-1:0] cap_base,
    input  logic [LEN_BITS-1:0]   cap_len,
    input  logic [1:0]            cap_perm,
    output logic                  err_valid,
    output logic [PID_BITS-1:0]   err_pid,
    output logic [1:0]            err_cause,
    output logic [31:0]           rej_cnt
);

    cap_t       cap_wr;
    cap_t       s1_cap;
    cap_t       s2_cap;
    req_t       s1_req;
    req_t       s2_req;
    logic       s1_valid;
    logic       s2_valid;
    logic       s2_free;
    logic       s_hs;
    logic [1:0] cause;

    assign cap_wr = '{base: cap_base, len: cap_len, perm: cap_perm};

    ceu_cap_table #(.N_CAPS(N_CAPS)) u_table (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (cap_wr_en),
        .wr_idx  (cap_idx),
        .wr_cap  (cap_wr),
        .rd_en   (s_hs),
        .rd_idx  (s_req_data.pid),
        .rd_cap  (s1_cap)
    );

    assign cause       = cap_cause(s2_req, s2_cap, IS_WR);
    assign m_req_valid = s2_valid && cause == CAP_ERR_NONE;
    assign err_valid   = s2_valid && cause != CAP_ERR_NONE;
    assign m_req_data  = s2_req;
    assign err_pid     = s2_req.pid;
    assign err_cause   = cause;
    assign s2_free     = !s2_valid || err_valid || m_req_ready;
    assign s_req_ready = !s1_valid || s2_free;
    assign s_hs        = s_req_valid && s_req_ready;

    // S1 occupancy; the table read register is the S1 copy of the entry
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            s1_valid <= 1'b0;
        else if (s_req_ready)
            s1_valid <= s_req_valid;
    end

    // S1 request payload
    always_ff @(posedge aclk) begin
        if (s_hs)
            s1_req <= s_req_data;
    end

    // S2 occupancy; a reject frees S2 in the same cycle it is reported
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            s2_valid <= 1'b0;
        else if (s2_free)
            s2_valid <= s1_valid;
    end

    // S2 payload snapshots request and entry together so later table writes cannot touch it
    always_ff @(posedge aclk) begin
        if (s2_free && s1_valid) begin
            s2_req <= s1_req;
            s2_cap <= s1_cap;
        end
    end

    // Saturating reject counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rej_cnt <= '0;
        else if (err_valid && rej_cnt != 32'hFFFF_FFFF)
            rej_cnt <= rej_cnt + 32'd1;
    end

endmodule

// File: tb/tb_ceu_cap_check.sv
// tb_ceu_cap_check: directed checks of forwarding, reject causes, backpressure, table hazards, saturation and reset
module tb_ceu_cap_check;
    import lynxTypes::*;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic                  s_req_valid;
    logic                  s_req_ready;
    req_t                  s_req_data;
    logic                  m_req_valid;
    logic                  m_req_ready;
    req_t                  m_req_data;
    logic                  cap_wr_en;
    logic [PID_BITS-1:0]   cap_idx;
    logic [VADDR_BITS-1:0] cap_base;
    logic [LEN_BITS-1:0]   cap_len;
    logic [1:0]            cap_perm;
    logic                  err_valid;
    logic [PID_BITS-1:0]   err_pid;
    logic [1:0]            err_cause;
    logic [31:0]           rej_cnt;

    logic                  w_s_valid;
    logic                  w_s_ready;
    req_t                  w_s_data;
    logic                  w_m_valid;
    req_t                  w_m_data;
    logic                  w_err_valid;
    logic [PID_BITS-1:0]   w_err_pid;
    logic [1:0]            w_err_cause;
    logic [31:0]           w_rej_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int exp_rej = 0;
    int got;
    int sent;
    req_t r;

    always #5 aclk = ~aclk;

    ceu_cap_check #(.N_CAPS(16), .IS_WR(1'b0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
        .cap_wr_en(cap_wr_en), .cap_idx(cap_idx), .cap_base(cap_base), .cap_len(cap_len), .cap_perm(cap_perm),
        .err_valid(err_valid), .err_pid(err_pid), .err_cause(err_cause), .rej_cnt(rej_cnt)
    );

    ceu_cap_check #(.N_CAPS(16), .IS_WR(1'b1)) dut_w (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(w_s_valid), .s_req_ready(w_s_ready), .s_req_data(w_s_data),
        .m_req_valid(w_m_valid), .m_req_ready(m_req_ready), .m_req_data(w_m_data),
        .cap_wr_en(cap_wr_en), .cap_idx(cap_idx), .cap_base(cap_base), .cap_len(cap_len), .cap_perm(cap_perm),
        .err_valid(w_err_valid), .err_pid(w_err_pid), .err_cause(w_err_cause), .rej_cnt(w_rej_cnt)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic [PID_BITS-1:0] pid, input logic [VADDR_BITS-1:0] va, input logic [LEN_BITS-1:0] len);
        req_t q;
        q.pid = pid;
        q.vaddr = va;
        q.len = len;
        return q;
    endfunction

    task automatic wr_cap(input logic [PID_BITS-1:0] idx, input logic [VADDR_BITS-1:0] base, input logic [LEN_BITS-1:0] len, input logic [1:0] perm);
        cap_wr_en = 1'b1;
        cap_idx = idx;
        cap_base = base;
        cap_len = len;
        cap_perm = perm;
        tick();
        cap_wr_en = 1'b0;
    endtask

    task automatic send(input req_t q);
        s_req_valid = 1'b1;
        s_req_data = q;
        chk1("send_ready", s_req_ready, 1'b1);
        tick();
        s_req_valid = 1'b0;
    endtask

    // One request through an idle pipeline on the read-path DUT, expected cause supplied by the caller
    task automatic check_req(input string tag, input req_t q, input logic [1:0] cause);
        send(q);
        chk1({tag, "_s1_quiet"}, m_req_valid || err_valid, 1'b0);
        tick();
        if (cause == CAP_ERR_NONE) begin
            chk1({tag, "_fwd_valid"}, m_req_valid, 1'b1);
            chk({tag, "_fwd_data"}, 128'(m_req_data), 128'(q));
            chk1({tag, "_fwd_noerr"}, err_valid, 1'b0);
        end else begin
            chk1({tag, "_err_valid"}, err_valid, 1'b1);
            chk({tag, "_err_pid"}, 128'(err_pid), 128'(q.pid));
            chk({tag, "_err_cause"}, 128'(err_cause), 128'(cause));
            chk1({tag, "_no_fwd"}, m_req_valid, 1'b0);
            exp_rej++;
        end
        tick();
        chk1({tag, "_pulse_end"}, err_valid || m_req_valid, 1'b0);
        chk({tag, "_rej_cnt"}, 128'(rej_cnt), 128'(exp_rej));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        s_req_valid = 1'b0;
        s_req_data = '0;
        m_req_ready = 1'b1;
        cap_wr_en = 1'b0;
        cap_idx = '0;
        cap_base = '0;
        cap_len = '0;
        cap_perm = 2'b00;
        w_s_valid = 1'b0;
        w_s_data = '0;
        repeat (2) tick();
        chk1("rst_m_valid", m_req_valid, 1'b0);
        chk1("rst_err_valid", err_valid, 1'b0);
        chk("rst_rej_cnt", 128'(rej_cnt), 128'(0));
        aresetn = 1'b1;
        #1;
        chk1("rst_s_ready", s_req_ready, 1'b1);

        wr_cap(6'd3, 48'h1000, 28'h1000, 2'b01);
        wr_cap(6'd4, 48'hFFFF_FFFF_0000, 28'hFFFF, 2'b01);
        wr_cap(6'd5, 48'h0, 28'h10000, 2'b11);

        check_req("in_window", mk(6'd3, 48'h1800, 28'h800), CAP_ERR_NONE);
        check_req("one_past_end", mk(6'd3, 48'h1800, 28'h801), CAP_ERR_BOUNDS);
        check_req("exact_fit", mk(6'd3, 48'h1000, 28'h1000), CAP_ERR_NONE);
        check_req("below_base", mk(6'd3, 48'h0FFF, 28'h10), CAP_ERR_BOUNDS);
        check_req("zero_len", mk(6'd3, 48'h1800, 28'h0), CAP_ERR_BOUNDS);
        check_req("pid_oob", mk(6'd20, 48'h1800, 28'h10), CAP_ERR_NOCAP);
        check_req("perm_zero", mk(6'd7, 48'h0, 28'h10), CAP_ERR_NOCAP);
        check_req("carry_out", mk(6'd4, 48'hFFFF_FFFF_F000, 28'h2000), CAP_ERR_BOUNDS);
        check_req("top_fit", mk(6'd4, 48'hFFFF_FFFF_E000, 28'h1000), CAP_ERR_NONE);

        w_s_valid = 1'b1;
        w_s_data = mk(6'd3, 48'h1800, 28'h800);
        tick();
        w_s_valid = 1'b0;
        tick();
        chk1("wr_perm_err_valid", w_err_valid, 1'b1);
        chk("wr_perm_cause", 128'(w_err_cause), 128'(CAP_ERR_PERM));
        chk("wr_perm_pid", 128'(w_err_pid), 128'(3));
        chk1("wr_perm_no_fwd", w_m_valid, 1'b0);
        w_s_valid = 1'b1;
        w_s_data = mk(6'd5, 48'h100, 28'h10);
        tick();
        w_s_valid = 1'b0;
        tick();
        chk1("wr_pass_valid", w_m_valid, 1'b1);
        chk("wr_pass_data", 128'(w_m_data), 128'(mk(6'd5, 48'h100, 28'h10)));
        chk("wr_rej_cnt", 128'(w_rej_cnt), 128'(1));
        tick();

        got = 0;
        sent = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            m_req_ready = (c >= 5);
            s_req_valid = (sent < 8);
            s_req_data = mk(6'd5, 48'(sent) * 48'h100, 28'h10);
            #1;
            if (c == 2)
                chk1("b2b_ready_low", s_req_ready, 1'b0);
            if (c >= 2 && c < 5)
                chk("b2b_hold", 128'({m_req_valid, m_req_data}), 128'({1'b1, mk(6'd5, 48'h0, 28'h10)}));
            if (m_req_valid && m_req_ready) begin
                chk("b2b_order", 128'(m_req_data), 128'(mk(6'd5, 48'(got) * 48'h100, 28'h10)));
                got++;
            end
            if (s_req_valid && s_req_ready)
                sent++;
            tick();
        end
        s_req_valid = 1'b0;
        m_req_ready = 1'b1;
        chk("b2b_count", 128'(got), 128'(8));
        chk("b2b_rej_cnt", 128'(rej_cnt), 128'(exp_rej));

        r = mk(6'd3, 48'h1800, 28'h800);
        cap_wr_en = 1'b1;
        cap_idx = 6'd3;
        cap_base = 48'h1000;
        cap_len = 28'h1000;
        cap_perm = 2'b00;
        s_req_valid = 1'b1;
        s_req_data = r;
        #1;
        chk1("hazard_ready", s_req_ready, 1'b1);
        tick();
        cap_wr_en = 1'b0;
        tick();
        s_req_valid = 1'b0;
        chk1("hazard_old_valid", m_req_valid, 1'b1);
        chk("hazard_old_data", 128'(m_req_data), 128'(r));
        chk1("hazard_old_noerr", err_valid, 1'b0);
        tick();
        chk1("hazard_new_err", err_valid, 1'b1);
        chk("hazard_new_cause", 128'(err_cause), 128'(CAP_ERR_NOCAP));
        chk1("hazard_new_no_fwd", m_req_valid, 1'b0);
        exp_rej++;
        tick();
        chk("hazard_rej_cnt", 128'(rej_cnt), 128'(exp_rej));

        force dut.rej_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.rej_cnt;
        #1;
        chk("sat_preload", 128'(rej_cnt), 128'(32'hFFFF_FFFE));
        s_req_valid = 1'b1;
        s_req_data = mk(6'd20, 48'h0, 28'h10);
        repeat (3) tick();
        s_req_valid = 1'b0;
        chk("sat_first", 128'(rej_cnt), 128'(32'hFFFF_FFFF));
        repeat (3) tick();
        chk("sat_hold", 128'(rej_cnt), 128'(32'hFFFF_FFFF));

        s_req_valid = 1'b1;
        s_req_data = mk(6'd5, 48'h200, 28'h10);
        tick();
        s_req_data = mk(6'd20, 48'h0, 28'h10);
        tick();
        s_req_valid = 1'b0;
        chk1("mid_fwd_before_rst", m_req_valid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk1("mid_rst_m_valid", m_req_valid, 1'b0);
        chk1("mid_rst_err_valid", err_valid, 1'b0);
        chk("mid_rst_rej_cnt", 128'(rej_cnt), 128'(0));
        repeat (2) tick();
        aresetn = 1'b1;
        #1;
        chk1("mid_rst_ready", s_req_ready, 1'b1);
        tick();
        chk1("mid_rst_quiet", m_req_valid || err_valid, 1'b0);
        exp_rej = 0;
        check_req("perm_cleared", mk(6'd5, 48'h100, 28'h10), CAP_ERR_NOCAP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ceu_cap_check.md
CEU_CAP_CHECK -- requirements
Module: ceu_cap_check

Interface
REQ-001 Parameter N_CAPS, default 16, number of capability entries, indexed by pid; N_CAPS SHALL be at most 2^PID_BITS.
REQ-002 Parameter IS_WR, default 0, meaning 0 = read path (checks R permission) and 1 = write path (checks W permission).
REQ-003 Port aclk, input, 1 bit: the single clock.
REQ-004 Port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Ports s_req_valid (input, 1), s_req_ready (output, 1) and s_req_data (input, req_t): the user request stream, upstream of the user request mux.
REQ-006 Ports m_req_valid (output, 1), m_req_ready (input, 1) and m_req_data (output, req_t): the checked request stream toward the CEU user descriptor input.
REQ-007 Ports cap_wr_en (input, 1), cap_idx (input, PID_BITS), cap_base (input, VADDR_BITS), cap_len (input, LEN_BITS) and cap_perm (input, 2; bit0 R, bit1 W): the capability programming port; cap_perm = 0 invalidates the entry.
REQ-008 Ports err_valid (output, 1), err_pid (output, PID_BITS) and err_cause (output, 2): the reject report.
REQ-009 Port rej_cnt, output, 32 bits: the count of rejected requests.

Function
REQ-010 The block SHALL keep a registered table of N_CAPS entries {base, len, perm}; a cap_wr_en write SHALL take effect on the next cycle.
REQ-011 The datapath SHALL be two stages: S1 registers the request plus the table entry read at pid; S2 evaluates the check and either drives m_req or drops the request.
REQ-012 Latency SHALL be 2 cycles from s_req handshake to m_req_valid; throughput SHALL be 1 request per cycle with m_req_ready held high.
REQ-013 s_req_ready SHALL be high when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty, S2 is being dropped, or the m_req handshake completes.
REQ-014 m_req_valid SHALL stay asserted and m_req_data stable until m_req_ready; AXI-style rules, no combinational path from m_req_ready to m_req_valid.
REQ-015 Rejection causes SHALL be evaluated in priority order: cause 1 when pid >= N_CAPS or perm = 0; cause 2 when the required permission bit is clear; cause 3 when len = 0, vaddr < base, vaddr+len carries out of VADDR_BITS, or vaddr+len > base+cap_len.
REQ-016 Bounds arithmetic SHALL be done at VADDR_BITS+1 width so that carry-out is detected, never wrapped.
REQ-017 A rejected request SHALL be consumed in S2 without asserting m_req_valid, and SHALL produce a one-cycle err_valid pulse in the same cycle with err_pid and err_cause.
REQ-018 rej_cnt SHALL increment by 1 per rejection and saturate at 0xFFFFFFFF.
REQ-019 A table write and an S1 lookup to the same index in the same cycle SHALL let the lookup observe the old entry.
REQ-020 A table write SHALL NOT affect a request already registered in S1 or S2.
REQ-021 Accepted requests SHALL be forwarded unmodified and in order.

Reset
REQ-022 Asserting aresetn low SHALL immediately clear all table perm fields, both stage-valid flags, m_req_valid, err_valid and rej_cnt; s_req_ready SHALL read 1 once aresetn is high.
REQ-023 Reset mid-transfer SHALL discard in-flight requests without reporting errors.
REQ-024 The table base and len fields need no reset.

Structure
REQ-025 VADDR_BITS, LEN_BITS, PID_BITS, req_t and a cap_t struct {base, len, perm} SHALL reside in lynxTypes, together with the cause encodings CAP_ERR_NONE=0, CAP_ERR_NOCAP=1, CAP_ERR_PERM=2 and CAP_ERR_BOUNDS=3.
REQ-026 The table SHALL be a sub-module, ceu_cap_table, with one synchronous write port and one registered read port.

Verification
REQ-027 With entry 3 = {base 0x1000, len 0x1000, perm R} and IS_WR=0, request pid 3, vaddr 0x1800, len 0x800 -> forwarded after 2 cycles, err_valid stays 0.
REQ-028 Same entry, vaddr 0x1800, len 0x801 -> dropped, err_valid pulse with pid 3 and cause 3, rej_cnt = 1.
REQ-029 IS_WR=1 with entry 3 perm R only -> cause 2; pid 20 with N_CAPS=16 -> cause 1; vaddr 0xFFFF_FFFF_F000 with len 0x2000 -> cause 3 (overflow).
REQ-030 Back-to-back 8 requests with m_req_ready held low for 5 cycles -> no loss, order preserved, s_req_ready deasserts after 2 accepted.
REQ-031 Write entry 3 perm=0 in the same cycle as a pid-3 request accept -> that request passes, the next pid-3 request is rejected with cause 1.
REQ-032 Force rej_cnt to 0xFFFFFFFE, then send 3 rejects -> rej_cnt reads 0xFFFFFFFF.
